ad7528_serial_writer: RTL and testbench

AD7528_SERIAL_WRITER -- requirements
Module: ad7528_serial_writer

---
 rtl/ad7528_serial_writer.sv | 106 ++++++++++
 tb/tb_ad7528_serial_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ad7528_serial_writer.sv
// ad7528_serial_writer: serializes {chan, value[7:0]} MSB first onto the AD7528 serial DAC bus.
// Define AD7528_WRITER_QUEUE_EN to let a request wait in a one-entry holding register for back-to-back frames.
module ad7528_serial_writer #(
    parameter int CLK_DIV = 15
) (
    input  logic       clk30,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_dac,
    input  logic       req_chan,
    input  logic [7:0] req_value,
    output logic       busy,
    output logic       done,
    output logic       datadac,
    output logic       clkdac,
    output logic       csdac1n,
    output logic       csdac2n
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SHIFT_LOW  = 2'd1;
    localparam logic [1:0] SHIFT_HIGH = 2'd2;
    localparam logic [1:0] DESELECT   = 2'd3;
    localparam logic [7:0] RELOAD     = 8'(CLK_DIV - 1);
    logic [1:0] state, state_n;
    logic [7:0] phase, phase_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [8:0] shreg, shreg_n, hold_frame;
    logic       dac_sel, dac_sel_n, hold_dac, hold_full;
    logic       done_n, accept, launch, tick, active_n;
    // The holding register also serves as the one-cycle pending slot between acceptance and chip select.
`ifdef AD7528_WRITER_QUEUE_EN
    assign req_ready = !hold_full;
`else
    assign req_ready = (state == IDLE) && !busy && !hold_full;
`endif
    assign accept   = req_valid && req_ready;
    assign tick     = phase == 8'd0;
    assign launch   = hold_full && (state == IDLE || (state == DESELECT && tick));
    assign active_n = state_n == SHIFT_LOW || state_n == SHIFT_HIGH;
    always_comb begin
        state_n   = state;
        phase_n   = (state == IDLE) ? phase : (tick ? RELOAD : phase - 8'd1);
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        dac_sel_n = dac_sel;
        done_n    = 1'b0;
        case (state)
            SHIFT_LOW:  if (tick) state_n = SHIFT_HIGH;
            SHIFT_HIGH: if (tick) begin
                state_n   = (bit_cnt == 4'd8) ? DESELECT : SHIFT_LOW;
                bit_cnt_n = bit_cnt + 4'd1;
                shreg_n   = {shreg[7:0], 1'b0};
            end
            DESELECT:   if (tick) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default:    state_n = state;
        endcase
        if (launch) begin
            state_n   = SHIFT_LOW;
            phase_n   = RELOAD;
            bit_cnt_n = 4'd0;
            shreg_n   = hold_frame;
            dac_sel_n = hold_dac;
        end
    end
    always_ff @(posedge clk30 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 8'd0;
            bit_cnt    <= 4'd0;
            shreg      <= 9'd0;
            dac_sel    <= 1'b0;
            hold_full  <= 1'b0;
            hold_frame <= 9'd0;
            hold_dac   <= 1'b0;
            datadac    <= 1'b0;
            clkdac     <= 1'b0;
            csdac1n    <= 1'b1;
            csdac2n    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            dac_sel <= dac_sel_n;
            datadac <= active_n && shreg_n[8];
            clkdac  <= state_n == SHIFT_HIGH;
            csdac1n <= !(active_n && !dac_sel_n);
            csdac2n <= !(active_n && dac_sel_n);
            busy    <= (state_n != IDLE) || done_n;
            done    <= done_n;
            if (launch) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full  <= 1'b1;
                hold_frame <= {req_chan, req_value};
                hold_dac   <= req_dac;
            end
        end
    end
endmodule

// File: tb/tb_ad7528_serial_writer.sv
// tb_ad7528_serial_writer: directed frame vectors plus reset-abort and back-to-back sequences
// on three writer instances (CLK_DIV 15, 2 and 4).
module tb_ad7528_serial_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] valid = '0, dac = '0, chan = '0;
    logic [7:0] value [3];
    logic [2:0] ready, busy, done, data, sclk, cs1, cs2;
    int vectors = 0;
    int errors = 0;
    typedef struct {
        int         inst;
        logic       d;
        logic       c;
        logic [7:0] v;
        logic [8:0] bits;
        int         cs;
        int         dn;
        bit         scr;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    ad7528_serial_writer #(.CLK_DIV(15)) u15 (
        .clk30(clk), .reset(reset), .req_valid(valid[0]), .req_ready(ready[0]), .req_dac(dac[0]),
        .req_chan(chan[0]), .req_value(value[0]), .busy(busy[0]), .done(done[0]), .datadac(data[0]),
        .clkdac(sclk[0]), .csdac1n(cs1[0]), .csdac2n(cs2[0]));
    ad7528_serial_writer #(.CLK_DIV(2)) u2 (
        .clk30(clk), .reset(reset), .req_valid(valid[1]), .req_ready(ready[1]), .req_dac(dac[1]),
        .req_chan(chan[1]), .req_value(value[1]), .busy(busy[1]), .done(done[1]), .datadac(data[1]),
        .clkdac(sclk[1]), .csdac1n(cs1[1]), .csdac2n(cs2[1]));
    ad7528_serial_writer #(.CLK_DIV(4)) u4 (
        .clk30(clk), .reset(reset), .req_valid(valid[2]), .req_ready(ready[2]), .req_dac(dac[2]),
        .req_chan(chan[2]), .req_value(value[2]), .busy(busy[2]), .done(done[2]), .datadac(data[2]),
        .clkdac(sclk[2]), .csdac1n(cs1[2]), .csdac2n(cs2[2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_frame(input vec_t t);
        int n = 0, rises = 0, cs_low = 0, first_low = -1, other_low = 0, glitch = 0;
        int done_at = -1, dones = 0, busy_gap = 0;
        logic [8:0] bits = '0;
        logic prev_clk = 1'b0, held = 1'b0, sel, oth;
        int i = t.inst;
        @(negedge clk);
        check("ready_idle", 32'(ready[i]), 1);
        valid[i] = 1'b1; dac[i] = t.d; chan[i] = t.c; value[i] = t.v;
        @(posedge clk); #1;
        valid[i] = 1'b0;
        while (n < t.dn + 3) begin
            @(posedge clk); #1;
            n++;
            if (t.scr) begin
                value[i] = ~value[i];
                chan[i]  = ~chan[i];
            end
            sel = t.d ? cs2[i] : cs1[i];
            oth = t.d ? cs1[i] : cs2[i];
            if (!sel) begin
                cs_low++;
                if (first_low < 0) first_low = n;
            end
            if (!oth) other_low++;
            if (sclk[i] && cs1[i] && cs2[i]) glitch++;
            if (sclk[i] && !prev_clk) begin
                bits = {bits[7:0], data[i]};
                rises++;
                held = data[i];
            end else if (sclk[i] && data[i] !== held) glitch++;
            prev_clk = sclk[i];
            if (done[i]) begin
                dones++;
                if (done_at < 0) done_at = n;
            end
            if (n <= t.dn && !busy[i]) busy_gap++;
        end
        check("cs_first_low", 32'(first_low), 1);
        check("cs_low_cycles", 32'(cs_low), 32'(t.cs));
        check("clk_rises", 32'(rises), 9);
        check("shifted_bits", 32'(bits), 32'(t.bits));
        check("other_cs_low", 32'(other_low), 0);
        check("clk_or_data_glitch", 32'(glitch), 0);
        check("done_cycle", 32'(done_at), 32'(t.dn));
        check("done_pulses", 32'(dones), 1);
        check("busy_gap", 32'(busy_gap), 0);
        check("busy_after", 32'(busy[i]), 0);
    endtask

    initial begin
        int n, a, b, c, d1, d2;
        value[0] = '0; value[1] = '0; value[2] = '0;
        vecs[0] = '{0, 1'b0, 1'b1, 8'hA5, 9'h1A5, 270, 286, 1'b0};
        vecs[1] = '{1, 1'b1, 1'b0, 8'h00, 9'h000, 36, 39, 1'b0};
        vecs[2] = '{1, 1'b0, 1'b0, 8'hFF, 9'h0FF, 36, 39, 1'b1};
        vecs[3] = '{1, 1'b1, 1'b1, 8'h5A, 9'h15A, 36, 39, 1'b0};
        vecs[4] = '{0, 1'b1, 1'b0, 8'h81, 9'h081, 270, 286, 1'b1};
        repeat (3) @(negedge clk);
        check("rst_cs1", 32'(cs1[0]), 1);
        check("rst_cs2", 32'(cs2[0]), 1);
        check("rst_clkdac", 32'(sclk[0]), 0);
        check("rst_datadac", 32'(data[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_done", 32'(done[0]), 0);
        reset = 1'b0;
        #1 check("ready_after_rst", 32'(ready[0]), 1);
        foreach (vecs[k]) run_frame(vecs[k]);

        // Reset in the middle of a D=15 frame: outputs must clear before any further clock edge.
        @(negedge clk);
        valid[0] = 1'b1; dac[0] = 1'b0; chan[0] = 1'b1; value[0] = 8'h3C;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1 check("mid_busy", 32'(busy[0]), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_cs1", 32'(cs1[0]), 1);
        check("abort_cs2", 32'(cs2[0]), 1);
        check("abort_clkdac", 32'(sclk[0]), 0);
        check("abort_datadac", 32'(data[0]), 0);
        check("abort_busy", 32'(busy[0]), 0);
        check("abort_done", 32'(done[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check("abort_ready", 32'(ready[0]), 1);
        a = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done[0]) a++;
        end
        check("abort_no_done", 32'(a), 0);
        run_frame(vecs[0]);

`ifdef AD7528_WRITER_QUEUE_EN
        // Second request waits in the holding register and follows after exactly D cycles of CS high.
        @(negedge clk);
        valid[2] = 1'b1; dac[2] = 1'b0; chan[2] = 1'b0; value[2] = 8'h3C;
        @(posedge clk); #1;
        value[2] = 8'hC3;
        n = 0; a = -1; b = -1; c = -1; d1 = -1; d2 = -1;
        while (n < 165) begin
            @(posedge clk); #1;
            n++;
            if (ready[2] && busy[2] && a < 0) a = n;
            if (a >= 0 && n == a + 1) valid[2] = 1'b0;
            if (cs1[2] && b < 0 && n > 1) b = n;
            if (!cs1[2] && b >= 0 && c < 0) c = n;
            if (done[2]) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
        end
        check("q_accept_busy", 32'(a), 1);
        check("q_cs_high_gap", 32'(c - b), 4);
        check("q_done1", 32'(d1), 77);
        check("q_done_spacing", 32'(d2 - d1), 76);
`else
        // Request held through a D=2 frame: not accepted until the frame has fully finished.
        @(negedge clk);
        valid[1] = 1'b1; dac[1] = 1'b0; chan[1] = 1'b1; value[1] = 8'h12;
        @(posedge clk); #1;
        dac[1] = 1'b1; chan[1] = 1'b0; value[1] = 8'hF0;
        n = 0; a = -1; c = -1; d1 = -1; d2 = -1;
        while (n < 90) begin
            @(posedge clk); #1;
            n++;
            if (ready[1] && a < 0) a = n;
            if (a >= 0 && n == a + 1) valid[1] = 1'b0;
            if (!cs2[1] && c < 0) c = n;
            if (done[1]) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
        end
        check("hold_ready_first", 32'(a), 40);
        check("hold_cs2_fall", 32'(c), 42);
        check("hold_done1", 32'(d1), 39);
        check("hold_done2", 32'(d2), 80);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
